// File: rtl/aes_iterative_core.sv
// Iterative AES encrypt/decrypt core: one round per clock, on-chip key expansion,
// independent valid/ready handshakes for key load, data input and result output.
module aes_iterative_core #(
  parameter int unsigned NK = 8,
  parameter int unsigned NB = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_valid,
  input  logic [32*NK-1:0] key,
  output logic            key_ready,
  output logic            key_ok,
  input  logic            in_valid,
  input  logic [127:0]    in_data,
  input  logic            in_decrypt,
  output logic            in_ready,
  output logic            out_valid,
  output logic [127:0]    out_data,
  output logic            out_decrypt,
  input  logic            out_ready
);
  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = NB * (NR + 1);
  localparam int unsigned IW = $clog2(NW);

  if (NB != 4) begin : gen_nb_check
    $error("aes_iterative_core: NB must be 4");
  end
  if (NK != 4 && NK != 6 && NK != 8) begin : gen_nk_check
    $error("aes_iterative_core: NK must be 4, 6 or 8");
  end

  typedef enum logic [0:0] {KIdle, KExp} kstate_e;
  typedef enum logic [1:0] {DIdle, DRun, DDone} dstate_e;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = ginv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  // Byte n sits at row n%4, column n/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int unsigned src;
    o = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [3:0][7:0] m;
    logic [7:0]      acc;
    logic [127:0]    o;
    m = inv ? {8'h09, 8'h0d, 8'h0b, 8'h0e} : {8'h01, 8'h01, 8'h03, 8'h02};
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        acc = '0;
        for (int unsigned k = 0; k < 4; k++) acc ^= gmul(s[127-8*(4*c+k) -: 8], m[(k+4-j)%4]);
        o[127-8*(4*c+j) -: 8] = acc;
      end
    end
    return o;
  endfunction

  logic [31:0]   w_q [NW];
  kstate_e       kst_q, kst_d;
  dstate_e       dst_q, dst_d;
  logic [IW-1:0] i_q, i_d;
  logic [2:0]    imod_q, imod_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          key_ok_q, key_ok_d;
  logic [3:0]    r_q, r_d;
  logic [127:0]  st_q, st_d, od_q, od_d;
  logic          dec_q, dec_d, odec_q, odec_d;
  logic          key_acc, in_acc;

  logic [31:0]  kprev, ksub_in, ktemp, kword;
  logic [127:0] sb_in, sb_out, isr, isb, enc_st, dec_st, rnd_st, rk;
  logic [3:0]   rk_idx;

  assign key_ready   = (kst_q == KIdle) && (dst_q == DIdle);
  assign in_ready    = (dst_q == DIdle) && key_ok_q && (kst_q == KIdle) && !key_valid;
  assign key_acc     = key_valid && key_ready;
  assign in_acc      = in_valid && in_ready;
  assign key_ok      = key_ok_q;
  assign out_valid   = (dst_q == DDone);
  assign out_data    = od_q;
  assign out_decrypt = odec_q;

  // The forward S-box bank serves key expansion in KExp and encryption rounds in DRun;
  // the two FSMs interlock so these never overlap.
  always_comb begin
    kprev   = w_q[i_q - IW'(1)];
    ksub_in = (imod_q == 3'd0) ? {kprev[23:0], kprev[31:24]} : kprev;
    sb_in   = st_q;
    if (kst_q == KExp) sb_in[127:96] = ksub_in;
    isr = shift_rows(st_q, 1'b1);
    for (int unsigned n = 0; n < 16; n++) begin
      sb_out[127-8*n -: 8] = sbox(sb_in[127-8*n -: 8]);
      isb[127-8*n -: 8]    = inv_sbox(isr[127-8*n -: 8]);
    end
    if (imod_q == 3'd0)                  ktemp = sb_out[127:96] ^ {rcon_q, 24'h0};
    else if (NK == 8 && imod_q == 3'd4)  ktemp = sb_out[127:96];
    else                                 ktemp = kprev;
    kword = w_q[i_q - IW'(NK)] ^ ktemp;

    if (dst_q == DIdle) rk_idx = in_decrypt ? 4'(NR) : 4'd0;
    else                rk_idx = dec_q ? 4'(NR) - r_q : r_q;
    rk = {w_q[{rk_idx, 2'b00}], w_q[{rk_idx, 2'b01}], w_q[{rk_idx, 2'b10}], w_q[{rk_idx, 2'b11}]};

    enc_st = shift_rows(sb_out, 1'b0);
    if (r_q != 4'(NR)) enc_st = mix_cols(enc_st, 1'b0);
    enc_st = enc_st ^ rk;
    dec_st = isb ^ rk;
    if (r_q != 4'(NR)) dec_st = mix_cols(dec_st, 1'b1);
    rnd_st = dec_q ? dec_st : enc_st;
  end

  always_comb begin
    kst_d    = kst_q;
    i_d      = i_q;
    imod_d   = imod_q;
    rcon_d   = rcon_q;
    key_ok_d = key_ok_q;
    unique case (kst_q)
      KIdle: begin
        if (key_acc) begin
          kst_d    = KExp;
          i_d      = IW'(NK);
          imod_d   = '0;
          rcon_d   = 8'h01;
          key_ok_d = 1'b0;
        end
      end
      KExp: begin
        i_d    = i_q + IW'(1);
        imod_d = (imod_q == 3'(NK - 1)) ? 3'd0 : imod_q + 3'd1;
        if (imod_q == 3'd0) rcon_d = xt(rcon_q);
        if (i_q == IW'(NW - 1)) begin
          kst_d    = KIdle;
          key_ok_d = 1'b1;
        end
      end
      default: kst_d = KIdle;
    endcase
  end

  always_comb begin
    dst_d  = dst_q;
    r_d    = r_q;
    st_d   = st_q;
    dec_d  = dec_q;
    od_d   = od_q;
    odec_d = odec_q;
    unique case (dst_q)
      DIdle: begin
        if (in_acc) begin
          st_d  = in_data ^ rk;
          r_d   = 4'd1;
          dec_d = in_decrypt;
          dst_d = DRun;
        end
      end
      DRun: begin
        if (r_q == 4'(NR)) begin
          od_d   = rnd_st;
          odec_d = dec_q;
          dst_d  = DDone;
        end else begin
          r_d  = r_q + 4'd1;
          st_d = rnd_st;
        end
      end
      DDone: if (out_ready) dst_d = DIdle;
      default: dst_d = DIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kst_q    <= KIdle;
      dst_q    <= DIdle;
      i_q      <= '0;
      imod_q   <= '0;
      rcon_q   <= 8'h01;
      key_ok_q <= 1'b0;
      r_q      <= '0;
      st_q     <= '0;
      dec_q    <= 1'b0;
      od_q     <= '0;
      odec_q   <= 1'b0;
    end else begin
      kst_q    <= kst_d;
      dst_q    <= dst_d;
      i_q      <= i_d;
      imod_q   <= imod_d;
      rcon_q   <= rcon_d;
      key_ok_q <= key_ok_d;
      r_q      <= r_d;
      st_q     <= st_d;
      dec_q    <= dec_d;
      od_q     <= od_d;
      odec_q   <= odec_d;
    end
  end

  // Round-key store is deliberately unreset; key_ok guards its contents.
  always_ff @(posedge clk) begin
    if (key_acc) begin
      for (int k = 0; k < int'(NK); k++) w_q[k] <= key[32*NK-1-32*k -: 32];
    end else if (kst_q == KExp) begin
      w_q[i_q] <= kword;
    end
  end

endmodule

// File: tb/tb_aes_iterative_core.sv
// Directed bench for aes_iterative_core: AES-128/192/256 builds side by side,
// FIPS-197 vectors, handshakes, backpressure, key priority and mid-operation reset.
module tb_aes_iterative_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [2:0]          kv, kr, kok, iv, ir, ov, odc, ord;
  logic [255:0]        key_bus;
  logic [127:0]        in_data;
  logic                in_dec;
  logic [2:0][127:0]   od;
  int total, bad;

  localparam logic [255:0] KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT1  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT2  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CTZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    aes_iterative_core #(.NK(4 + 2 * g), .NB(4)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_valid  (kv[g]),
      .key        (key_bus[255 -: 32*(4+2*g)]),
      .key_ready  (kr[g]),
      .key_ok     (kok[g]),
      .in_valid   (iv[g]),
      .in_data    (in_data),
      .in_decrypt (in_dec),
      .in_ready   (ir[g]),
      .out_valid  (ov[g]),
      .out_data   (od[g]),
      .out_decrypt(odc[g]),
      .out_ready  (ord[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input int d, input logic [255:0] k, output int lat);
    key_bus = k;
    kv[d] = 1'b1;
    lat = -1;
    for (int n = 0; n < 50 && !kr[d]; n++) tick();
    tick();
    kv[d] = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (kok[d]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_block(input int d, input logic [127:0] din, input logic dec,
                           output logic [127:0] dout, output logic dout_dec, output int lat);
    in_data = din;
    in_dec = dec;
    iv[d] = 1'b1;
    lat = -1;
    for (int n = 0; n < 100 && !ir[d]; n++) tick();
    tick();
    iv[d] = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (ov[d]) begin
        lat = n;
        break;
      end
    end
    dout = od[d];
    dout_dec = odc[d];
    ord[d] = 1'b1;
    tick();
    ord[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      total += 6;
      if (kr[d] !== 1'b1) begin bad++; $display("FAIL reset_key_ready d=%0d: got %b want 1", d, kr[d]); end
      if (kok[d] !== 1'b0) begin bad++; $display("FAIL reset_key_ok d=%0d: got %b want 0", d, kok[d]); end
      if (ir[d] !== 1'b0) begin bad++; $display("FAIL reset_in_ready d=%0d: got %b want 0", d, ir[d]); end
      if (ov[d] !== 1'b0) begin bad++; $display("FAIL reset_out_valid d=%0d: got %b want 0", d, ov[d]); end
      if (od[d] !== 128'h0) begin bad++; $display("FAIL reset_out_data d=%0d: got %h want 0", d, od[d]); end
      if (odc[d] !== 1'b0) begin bad++; $display("FAIL reset_out_decrypt d=%0d: got %b want 0", d, odc[d]); end
    end
  endtask

  task automatic test_hold_off();
    int seen;
    seen = 0;
    in_data = PT;
    in_dec = 1'b0;
    iv[0] = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if (ir[0] || ov[0]) seen++;
      tick();
    end
    iv[0] = 1'b0;
    total++;
    if (seen !== 0) begin bad++; $display("FAIL hold_off: got %0d ready/valid cycles want 0", seen); end
  endtask

  task automatic test_cipher(input int d, input logic [127:0] ct);
    int nr, nk, lat;
    logic [127:0] res;
    logic rdec;
    nr = 10 + 2 * d;
    nk = 4 + 2 * d;
    load_key(d, KEY, lat);
    total++;
    if (lat !== 4 * (nr + 1) - nk) begin
      bad++; $display("FAIL key_latency d=%0d: got %0d want %0d", d, lat, 4 * (nr + 1) - nk);
    end
    run_block(d, PT, 1'b0, res, rdec, lat);
    total += 3;
    if (res !== ct) begin bad++; $display("FAIL encrypt d=%0d: got %h want %h", d, res, ct); end
    if (lat !== nr) begin bad++; $display("FAIL enc_latency d=%0d: got %0d want %0d", d, lat, nr); end
    if (rdec !== 1'b0) begin bad++; $display("FAIL enc_out_decrypt d=%0d: got %b want 0", d, rdec); end
    run_block(d, ct, 1'b1, res, rdec, lat);
    total += 3;
    if (res !== PT) begin bad++; $display("FAIL decrypt d=%0d: got %h want %h", d, res, PT); end
    if (lat !== nr) begin bad++; $display("FAIL dec_latency d=%0d: got %0d want %0d", d, lat, nr); end
    if (rdec !== 1'b1) begin bad++; $display("FAIL dec_out_decrypt d=%0d: got %b want 1", d, rdec); end
  endtask

  task automatic test_key_wins();
    int lat, wait_n;
    logic [127:0] res;
    logic rdec;
    load_key(0, 256'h0, lat);
    run_block(0, 128'h0, 1'b0, res, rdec, lat);
    total++;
    if (res !== CTZ) begin bad++; $display("FAIL zero_key_encrypt: got %h want %h", res, CTZ); end
    key_bus = KEY;
    in_data = PT;
    in_dec = 1'b0;
    kv[0] = 1'b1;
    iv[0] = 1'b1;
    #1;
    total += 2;
    if (ir[0] !== 1'b0) begin bad++; $display("FAIL key_wins_in_ready: got %b want 0", ir[0]); end
    if (kr[0] !== 1'b1) begin bad++; $display("FAIL key_wins_key_ready: got %b want 1", kr[0]); end
    tick();
    kv[0] = 1'b0;
    wait_n = -1;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (ir[0]) begin
        wait_n = n;
        break;
      end
    end
    total++;
    if (wait_n !== 40) begin bad++; $display("FAIL key_wins_stall: got %0d want 40", wait_n); end
    tick();
    iv[0] = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (ov[0]) begin
        lat = n;
        break;
      end
    end
    total += 2;
    if (lat !== 10) begin bad++; $display("FAIL key_wins_latency: got %0d want 10", lat); end
    if (od[0] !== CT0) begin bad++; $display("FAIL key_wins_result: got %h want %h", od[0], CT0); end
    ord[0] = 1'b1;
    tick();
    ord[0] = 1'b0;
  endtask

  task automatic test_backpressure();
    int stamps[$];
    int lat;
    in_data = PT;
    in_dec = 1'b0;
    iv[0] = 1'b1;
    for (int n = 0; n < 50 && !ir[0]; n++) tick();
    tick();
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (ov[0]) begin
        lat = n;
        break;
      end
    end
    total++;
    if (lat !== 10) begin bad++; $display("FAIL bp_latency: got %0d want 10", lat); end
    kv[0] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      total += 4;
      if (ov[0] !== 1'b1) begin bad++; $display("FAIL bp_out_valid c=%0d: got %b want 1", n, ov[0]); end
      if (od[0] !== CT0) begin bad++; $display("FAIL bp_out_data c=%0d: got %h want %h", n, od[0], CT0); end
      if (ir[0] !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d: got %b want 0", n, ir[0]); end
      if (kr[0] !== 1'b0) begin bad++; $display("FAIL bp_key_ready c=%0d: got %b want 0", n, kr[0]); end
      tick();
    end
    kv[0] = 1'b0;
    ord[0] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (ov[0]) begin
        stamps.push_back(c);
        total++;
        if (od[0] !== CT0) begin bad++; $display("FAIL b2b_data c=%0d: got %h want %h", c, od[0], CT0); end
      end
      tick();
    end
    iv[0] = 1'b0;
    for (int n = 0; n < 20; n++) tick();
    ord[0] = 1'b0;
    total++;
    if (stamps.size() !== 5) begin bad++; $display("FAIL b2b_count: got %0d want 5", stamps.size()); end
    for (int k = 1; k < stamps.size(); k++) begin
      total++;
      if (stamps[k] - stamps[k-1] !== 12) begin
        bad++; $display("FAIL b2b_interval k=%0d: got %0d want 12", k, stamps[k] - stamps[k-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, seen;
    logic [127:0] res;
    logic rdec;
    key_bus = KEY;
    kv[1] = 1'b1;
    for (int n = 0; n < 50 && !kr[1]; n++) tick();
    tick();
    kv[1] = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    rst_n = 1'b0;
    #1;
    total += 3;
    if (kok[1] !== 1'b0) begin bad++; $display("FAIL kexp_rst_key_ok: got %b want 0", kok[1]); end
    if (ov[1] !== 1'b0) begin bad++; $display("FAIL kexp_rst_out_valid: got %b want 0", ov[1]); end
    if (kr[1] !== 1'b1) begin bad++; $display("FAIL kexp_rst_key_ready: got %b want 1", kr[1]); end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      if (kok[1] || ir[1]) seen++;
      tick();
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL kexp_rst_resumed: got %0d cycles want 0", seen); end
    load_key(1, KEY, lat);
    total++;
    if (lat !== 46) begin bad++; $display("FAIL reload_key_latency: got %0d want 46", lat); end
    in_data = PT;
    in_dec = 1'b0;
    iv[1] = 1'b1;
    for (int n = 0; n < 50 && !ir[1]; n++) tick();
    tick();
    for (int n = 0; n < 5; n++) tick();
    rst_n = 1'b0;
    #1;
    total += 4;
    if (ov[1] !== 1'b0) begin bad++; $display("FAIL drun_rst_out_valid: got %b want 0", ov[1]); end
    if (kok[1] !== 1'b0) begin bad++; $display("FAIL drun_rst_key_ok: got %b want 0", kok[1]); end
    if (ir[1] !== 1'b0) begin bad++; $display("FAIL drun_rst_in_ready: got %b want 0", ir[1]); end
    if (od[1] !== 128'h0) begin bad++; $display("FAIL drun_rst_out_data: got %h want 0", od[1]); end
    tick();
    rst_n = 1'b1;
    iv[1] = 1'b0;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      if (ov[1]) seen++;
      tick();
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL drun_rst_resumed: got %0d cycles want 0", seen); end
    load_key(1, KEY, lat);
    run_block(1, PT, 1'b0, res, rdec, lat);
    total += 2;
    if (res !== CT1) begin bad++; $display("FAIL reload_result: got %h want %h", res, CT1); end
    if (lat !== 12) begin bad++; $display("FAIL reload_latency: got %0d want 12", lat); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    kv = '0;
    iv = '0;
    ord = '0;
    key_bus = '0;
    in_data = '0;
    in_dec = 1'b0;
    test_reset();
    test_hold_off();
    test_cipher(0, CT0);
    test_cipher(1, CT1);
    test_cipher(2, CT2);
    test_key_wins();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_iterative_core.md
# aes_iterative_core

Sequential, parametrised AES core that runs one round per clock over a shared datapath and stores an internally expanded key schedule. It supports both encryption and decryption, selected per block. It supersedes the fully-unrolled combinational encrypt path for area-constrained use. Key loading and data transfer use independent valid/ready handshakes.

## Interface

Parameters:
- `NK`, default 8: key length in 32-bit words; legal values are 4, 6, 8 (AES-128/192/256).
- `NB`, default 4: state columns; fixed at 4, and any other value fails elaboration.
- `NR` (localparam), equal to NK+6: rounds.

Ports:
- `clk`, in, 1: single clock, rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `key_valid`, in, 1: key offer.
- `key`, in, 32*NK: cipher key; `key[32*NK-1 -: 8]` is key byte 0.
- `key_ready`, out, 1: key accepted when key_valid & key_ready.
- `key_ok`, out, 1: round-key schedule complete and valid.
- `in_valid`, in, 1: data offer.
- `in_data`, in, 128: block; `in_data[127:120]` is state byte 0 (FIPS-197 order).
- `in_decrypt`, in, 1: 0 encrypts, 1 decrypts; sampled with in_data.
- `in_ready`, out, 1: block accepted when in_valid & in_ready.
- `out_valid`, out, 1: result available.
- `out_data`, out, 128: result, same byte order as in_data.
- `out_decrypt`, out, 1: mode of the block on out_data.
- `out_ready`, in, 1: result consumed when out_valid & out_ready.

## Operation

- Round-key store: 4*(NR+1) 32-bit words (44/52/60). The store is not reset.
- Key FSM states: KIDLE, KEXP.
  - On key accept: w[0..NK-1] are loaded from key, key_ok is cleared, and the FSM enters KEXP with i=NK and rcon=0x01.
  - KEXP generates one word per cycle: temp=w[i-1]. If i mod NK==0: temp=SubWord(RotWord(temp))^{rcon,24'h0}, and rcon becomes xtime(rcon). Else if NK==8 and i mod NK==4: temp=SubWord(temp). Then w[i]=w[i-NK]^temp.
  - The FSM tracks i mod NK with a wrapping counter, not a divider.
  - After w[4*(NR+1)-1] is written, it returns to KIDLE and sets key_ok.
- `key_ready` is 1 only in KIDLE with the data FSM in DIDLE. A key cannot change under an in-flight or unconsumed block.
- Data FSM states: DIDLE, DRUN, DDONE.
- `in_ready` is 1 only in DIDLE with key_ok=1 and the key FSM in KIDLE.
- On accept:
  - Encrypt: state=in_data^rk[0].
  - Decrypt: state=in_data^rk[NR].
  - Round counter r=1; next state DRUN.
- DRUN, encrypt: SubBytes, ShiftRows, MixColumns (skipped when r==NR), then ^rk[r].
- DRUN, decrypt (straight inverse cipher): InvShiftRows, InvSubBytes, then ^rk[NR-r], then InvMixColumns (skipped when r==NR).
- When r==NR, the result is loaded into out_data and the FSM goes to DDONE with out_valid=1. Otherwise r increments.
- DDONE holds out_data, out_decrypt and out_valid stable until out_ready. It then returns to DIDLE and clears out_valid.
- The S-box is shared between the key path and the data path; they are never active in the same cycle.

## Timing

- Reset values:
  - key_ready=1, key_ok=0, in_ready=0, out_valid=0, out_data=0, out_decrypt=0.
  - Both FSMs in idle states, r=0, rcon=0x01.
- Key latency: key_ok rises 4*(NR+1)-NK cycles after the accept edge (40/46/52 for NK=4/6/8).
- Data latency: out_valid rises NR cycles after the accept edge (10/12/14).
- Throughput with out_ready held high: one block per NR+2 cycles (accept, NR rounds, one DDONE cycle).
- in_ready is 0 from the accept edge until the cycle after the output handshake. There is no accept in the same cycle as an output handshake.
- If key_valid and in_valid are both high in DIDLE with key_ok=1, the key wins. in_ready is forced 0 that cycle.
- If rst_n is asserted mid-KEXP or mid-DRUN, all state returns to reset values immediately. key_ok=0 until a new key is loaded.
- Data offered while key_ok=0 is held off (in_ready=0) indefinitely and never dropped.

## Test plan

- AES-128: NK=4, key 000102…0f, encrypt 00112233445566778899aabbccddeeff. Required: key_ok after 40 cycles; out_data 69c4e0d86a7b0430d8cdb78070b4c55a, 10 cycles after accept.
- AES-192 and AES-256 builds, same plaintext, keys 00..17 and 00..1f. Required: dda97ca4864cdfe06eaf70a0ec0d7191 after 12 rounds; 8ea2b7ca516745bfeafc49904b496089 after 14 rounds.
- Decrypt each ciphertext above with in_decrypt=1. Required: the plaintext returns with out_decrypt=1 and the same latency.
- Hold out_ready=0 for 20 cycles after out_valid. Required: out_data stable, in_ready=0, key_ready=0; consume, then back-to-back blocks arrive every NR+2 cycles.
- Assert rst_n low for one cycle mid-KEXP and again mid-DRUN. Required: out_valid=0, key_ok=0, in_ready=0; reload the key and block and get the correct result.
- Offer key_valid and in_valid together in idle. Required: the key is taken, the block stalls until key_ok, and the block is then encrypted under the new key.
